uart_rx_core: RTL and testbench

//  Oversampling UART receive engine for the AHB UART peripheral. It sits between the RsRx pad and the rx FIFO write port.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_filter.sv | 29 ++
 rtl/uart_rx_core.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receive FSM state encoding.
// Used by uart_rx_filter and uart_rx_core; optional parity is selected by UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DBIT_DEF       = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICK_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Serial line conditioning: 2-flop synchroniser feeding a 3-tap majority vote
// sampled on baud_tick, so pulses shorter than two ticks never reach rx_s.
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic baud_tick,
  input  logic rx,
  output logic rx_s
);

  logic [1:0] sync;
  logic [2:0] taps;

  // Reset to the idle (high) line level so a reset never looks like a start bit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync <= 2'b11;
      taps <= 3'b111;
    end else begin
      sync <= {sync[0], rx};
      if (baud_tick) taps <= {taps[1:0], sync[1]};
    end
  end

  assign rx_s = maj3(taps);

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receive engine (8N1, LSB first) feeding the rx FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit check and the parity_err strobe.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low on a tick
// START  | confirming start bit at mid-bit
// DATA   | sampling DBIT data bits at mid-bit
// PARITY | sampling parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling stop bit, issuing rx_done or frame_err
// BREAK  | line held low after a framing error, waiting for high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SB_TICK    = SB_TICK_DEF
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            baud_tick,
  input  logic            rx,
  output logic            rx_done,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            busy
`ifdef UART_RX_PARITY_EN
  , output logic          parity_err
`endif
);

  localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT + 1);

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

  rx_state_t       state;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] shreg;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
`endif

  uart_rx_filter u_filter (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_s      (rx_s)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (baud_tick) begin
        unique case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == T_HALF) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_DATA: begin
            if (tick_cnt == T_BIT) begin
              tick_cnt <= '0;
              shreg    <= DBIT'({rx_s, shreg} >> 1);
              if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt == T_BIT) begin
              tick_cnt <= '0;
              par_bad  <= ^{shreg, rx_s};
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif
          ST_STOP: begin
            if (tick_cnt == T_STOP) begin
              tick_cnt <= '0;
              if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                if (par_bad) begin
                  parity_err <= 1'b1;
                end else begin
                  rx_done <= 1'b1;
                  dout    <= shreg;
                end
`else
                rx_done <= 1'b1;
                dout    <= shreg;
`endif
                state <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          // Only a high line ends a break; a held-low line must not restart framing.
          ST_BREAK: begin
            if (rx_s) begin
              state    <= ST_IDLE;
              tick_cnt <= '0;
            end
          end
          default: begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed cases plus random frames,
// checked against a frame-level expectation queue. Honours UART_RX_PARITY_EN.
module tb_uart_rx_core;

  localparam int OS      = 16;
  localparam int TPB     = 4;
  localparam int BIT_CYC = OS * TPB;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_done, frame_err, busy;
  logic [7:0] dout;
  logic       parity_err;

  uart_rx_core dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_done   (rx_done),
    .dout      (dout),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  initial forever begin
    @(negedge HCLK);
    cyc++;
    baud_tick = (cyc % TPB == 0);
  end

  typedef enum int {EV_DONE = 0, EV_FERR = 1, EV_PERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_dout = 8'h00;
  int tests = 0, fails = 0;
  int n_done = 0, n_ferr = 0, n_perr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic idle(input int ticks);
    rx = 1'b1;
    wait_cyc(ticks * TPB);
  endtask

  // Sends the first nbits of a frame; a complete frame registers its expected outcome
  // at the start of the stop bit, with the strobe due around mid stop-bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_ok,
                            input int nbits);
    logic bits[$];
    ev_t  ev;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (PAR) bits.push_back(par_ok ? even_par(b) : ~even_par(b));
    bits.push_back(stop_bit);
    for (int i = 0; i < bits.size() && i < nbits; i++) begin
      if (i == bits.size() - 1) begin
        ev.data = b;
        ev.lo   = cyc + BIT_CYC * 3 / 8;
        ev.hi   = cyc + BIT_CYC - 2;
        if (!stop_bit)          ev.kind = EV_FERR;
        else if (PAR && !par_ok) ev.kind = EV_PERR;
        else                    ev.kind = EV_DONE;
        exp_q.push_back(ev);
      end
      rx = bits[i];
      wait_cyc(BIT_CYC);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1, 99);
  endtask

  // Compare process: strobe order/kind/timing against the queue, dout every cycle.
  initial begin
    ev_t      ev;
    ev_kind_t got;
    forever begin
      @(posedge HCLK);
      #1;
      if (!HRESETn) begin
        model_dout = 8'h00;
        continue;
      end
      if (rx_done | frame_err | parity_err) begin
        if (rx_done) n_done++;
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got done=%0b ferr=%0b perr=%0b required none (cycle %0d)",
                   rx_done, frame_err, parity_err, cyc);
        end else begin
          ev  = exp_q.pop_front();
          got = rx_done ? EV_DONE : (frame_err ? EV_FERR : EV_PERR);
          check("strobe_kind", 32'(got), 32'(ev.kind));
          check("strobe_onehot", 32'(rx_done) + 32'(frame_err) + 32'(parity_err), 32'd1);
          tests++;
          if (cyc < ev.lo || cyc > ev.hi) begin
            fails++;
            $display("FAIL strobe_time: got cycle %0d required %0d..%0d", cyc, ev.lo, ev.hi);
          end
          if (ev.kind == EV_DONE) model_dout = ev.data;
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
        ev = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_strobe: got none required kind %0d byte %0h", ev.kind, ev.data);
      end
      check("dout", 32'(dout), 32'(model_dout));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_done"}, 32'(rx_done), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
  endtask

  initial begin
    int d0, f0, p0;
    logic [7:0] b;
    int kind;

    check("pin_par_07", 32'(even_par(8'h07)), 32'd1);
    check("pin_par_a5", 32'(even_par(8'hA5)), 32'd0);
    check("pin_par_81", 32'(even_par(8'h81)), 32'd0);

    HRESETn = 1'b0;
    wait_cyc(6);
    check_reset_outputs("rst");
    HRESETn = 1'b1;
    idle(6);

    // 1: single character
    d0 = n_done; f0 = n_ferr;
    send_byte(8'hA5);
    idle(4);
    check("t1_ndone", 32'(n_done - d0), 32'd1);
    check("t1_nferr", 32'(n_ferr - f0), 32'd0);
    check("t1_dout", 32'(dout), 32'hA5);

    // 2: back-to-back, no idle gap
    d0 = n_done;
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(4);
    check("t2_ndone", 32'(n_done - d0), 32'd2);
    check("t2_dout", 32'(dout), 32'hFF);

    // 3: one-tick glitch
    d0 = n_done; f0 = n_ferr;
    rx = 1'b0;
    wait_cyc(TPB);
    idle(8);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_ndone", 32'(n_done - d0), 32'd0);
    check("t3_nferr", 32'(n_ferr - f0), 32'd0);

    // 4: stop bit low, then line held low
    d0 = n_done; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b1, 99);
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(10 * TPB);
      check("t4_busy_low", 32'(busy), 32'd1);
    end
    idle(8);
    check("t4_busy_idle", 32'(busy), 32'd0);
    check("t4_nferr", 32'(n_ferr - f0), 32'd1);
    check("t4_ndone", 32'(n_done - d0), 32'd0);
    check("t4_dout", 32'(dout), 32'hFF);

    // 5: reset during data bit 4
    send_frame(8'h5A, 1'b1, 1'b1, 5);
    rx = 1'b1;  // bit 4 of 0x5A
    wait_cyc(BIT_CYC / 2);
    check("t5_busy_mid", 32'(busy), 32'd1);
    HRESETn = 1'b0;
    rx = 1'b1;
    wait_cyc(4);
    check_reset_outputs("t5_rst");
    HRESETn = 1'b1;
    idle(20);
    d0 = n_done;
    send_byte(8'h81);
    idle(4);
    check("t5_ndone", 32'(n_done - d0), 32'd1);
    check("t5_dout", 32'(dout), 32'h81);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    d0 = n_done; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, 99);
    idle(4);
    check("t6_dout_ok", 32'(dout), 32'h07);
    check("t6_ndone", 32'(n_done - d0), 32'd1);
    send_frame(8'h07, 1'b1, 1'b0, 99);
    idle(4);
    check("t6_nperr", 32'(n_perr - p0), 32'd1);
    check("t6_ndone_bad", 32'(n_done - d0), 32'd1);
    check("t6_dout_kept", 32'(dout), 32'h07);
`else
    p0 = n_perr;
    check("t6_no_perr", 32'(n_perr - p0), 32'd0);
`endif

    // Random mix of good frames, framing errors, parity errors and glitches.
    for (int n = 0; n < 36; n++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_frame(b, 1'b0, 1'b1, 99);
        idle(6);
      end else if (kind == 1 && PAR) begin
        send_frame(b, 1'b1, 1'b0, 99);
        idle($urandom_range(0, 3));
      end else if (kind == 2) begin
        rx = 1'b0;
        wait_cyc(TPB);
        idle(6);
      end else begin
        send_byte(b);
        idle($urandom_range(0, 3));
      end
    end
    idle(10);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
